mesi_isc_cbus_resp: RTL and testbench

Per-CPU coherence-bus responder: the CPU-side end of the MESI ISC coherence bus. Sits between one CPU's cbus command slot from the broadcast controller and that CPU's private cache. Executes snoops (write-back/invalidate/downgrade) and enable-access grants against a local line-state array, then returns a single-cycle ack. One instance per CPU; four per system.

---
 rtl/mesi_isc_pkg.sv | 35 +++
 rtl/mesi_isc_cbus_resp_if.sv | 33 +++
 rtl/mesi_isc_line_state_ram.sv | 36 +++
 rtl/mesi_isc_cbus_resp.sv | 159 +++++++++++++++
 tb/tb_mesi_isc_cbus_resp.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mesi_isc_pkg.sv
// Shared MESI ISC coherence-bus types: cbus command codes, MESI line states
// and the per-CPU responder FSM states.
package mesi_isc_pkg;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_WR_SNOOP = 3'd1,
        CMD_RD_SNOOP = 3'd2,
        CMD_EN_WR    = 3'd3,
        CMD_EN_RD    = 3'd4
    } cbus_cmd_t;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_state_t;

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_LOOKUP,
        FSM_WB,
        FSM_EN_WAIT,
        FSM_ACK,
        FSM_WAIT_NOP
    } resp_state_t;

    // Codes 5-7 are reserved and behave like NOP.
    function automatic logic cmd_is_valid(input cbus_cmd_t cmd);
        return (cmd == CMD_WR_SNOOP) || (cmd == CMD_RD_SNOOP) ||
               (cmd == CMD_EN_WR)    || (cmd == CMD_EN_RD);
    endfunction

endpackage

// File: rtl/mesi_isc_cbus_resp_if.sv
// Signal bundle between the broadcast controller / private cache (master)
// and one CPU's coherence-bus responder (slave).
interface mesi_isc_cbus_resp_if #(
    parameter int unsigned CBUS_CMD_WIDTH = 3,
    parameter int unsigned ADDR_WIDTH     = 32
);
    logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i;
    logic [ADDR_WIDTH-1:0]     cbus_addr_i;
    logic                      cbus_ack_o;
    logic                      wb_req_o;
    logic [ADDR_WIDTH-1:0]     wb_addr_o;
    logic                      wb_done_i;
    logic                      en_o;
    logic                      en_wr_o;
    logic                      local_done_i;
    logic                      upd_valid_i;
    logic [ADDR_WIDTH-1:0]     upd_addr_i;
    logic [1:0]                upd_state_i;
    logic                      upd_ready_o;

    modport slave (
        input  cbus_cmd_i, cbus_addr_i, wb_done_i, local_done_i,
               upd_valid_i, upd_addr_i, upd_state_i,
        output cbus_ack_o, wb_req_o, wb_addr_o, en_o, en_wr_o, upd_ready_o
    );

    modport master (
        output cbus_cmd_i, cbus_addr_i, wb_done_i, local_done_i,
               upd_valid_i, upd_addr_i, upd_state_i,
        input  cbus_ack_o, wb_req_o, wb_addr_o, en_o, en_wr_o, upd_ready_o
    );

endinterface

// File: rtl/mesi_isc_line_state_ram.sv
// Direct-mapped {tag, state} array: registered read port, one write port,
// asynchronous clear of every entry (state I) on rst.
module mesi_isc_line_state_ram #(
    parameter int unsigned SET_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SET_WIDTH-1:0]  rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  we_i,
    input  logic [SET_WIDTH-1:0]  wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);
    localparam int unsigned DEPTH = 1 << SET_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_idx_i];
            if (we_i) begin
                mem_q[wr_idx_i] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mesi_isc_cbus_resp.sv
// Per-CPU coherence-bus responder: executes snoops and enable grants against
// the local line-state array and returns a single-cycle ack per command.
module mesi_isc_cbus_resp
    import mesi_isc_pkg::*;
#(
    parameter int unsigned CBUS_CMD_WIDTH = 3,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SET_WIDTH      = 4,
    parameter int unsigned OFF_WIDTH      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mesi_isc_cbus_resp_if.slave  bus
);
    localparam int unsigned TAG_WIDTH  = ADDR_WIDTH - SET_WIDTH - OFF_WIDTH;
    localparam int unsigned LINE_WIDTH = ADDR_WIDTH - OFF_WIDTH;
    localparam int unsigned ENT_WIDTH  = TAG_WIDTH + 2;

    resp_state_t             state_q, state_d;
    cbus_cmd_t               cmd_q, cmd_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    mesi_state_t             pend_q, pend_d;

    logic [SET_WIDTH-1:0]    rd_idx, wr_idx;
    logic [ENT_WIDTH-1:0]    rd_data, wr_data;
    logic                    we;

    cbus_cmd_t               cmd_in;
    logic                    cmd_valid;
    logic [TAG_WIDTH-1:0]    line_tag;
    logic [SET_WIDTH-1:0]    line_idx;
    mesi_state_t             ent_state;
    logic                    hit;
    logic                    unused_ok;

    assign cmd_in    = cbus_cmd_t'(bus.cbus_cmd_i);
    assign cmd_valid = cmd_is_valid(cmd_in);
    assign line_tag  = line_q[LINE_WIDTH-1:SET_WIDTH];
    assign line_idx  = line_q[SET_WIDTH-1:0];
    assign ent_state = mesi_state_t'(rd_data[1:0]);
    assign hit       = (rd_data[ENT_WIDTH-1:2] == line_tag) && (ent_state != MESI_I);
    assign unused_ok = ^{bus.cbus_addr_i[OFF_WIDTH-1:0], bus.upd_addr_i[OFF_WIDTH-1:0]};

    mesi_isc_line_state_ram #(
        .SET_WIDTH  (SET_WIDTH),
        .DATA_WIDTH (ENT_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data),
        .we_i      (we),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FSM_IDLE;
            cmd_q   <= CMD_NOP;
            line_q  <= '0;
            pend_q  <= MESI_I;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            line_q  <= line_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        line_d          = line_q;
        pend_d          = pend_q;
        rd_idx          = line_idx;
        we              = 1'b0;
        wr_idx          = line_idx;
        wr_data         = {line_tag, pend_q};
        bus.cbus_ack_o  = 1'b0;
        bus.wb_req_o    = 1'b0;
        bus.wb_addr_o   = '0;
        bus.en_o        = 1'b0;
        bus.en_wr_o     = 1'b0;
        bus.upd_ready_o = 1'b0;

        unique case (state_q)
            FSM_IDLE: begin
                // Read is launched here so the registered result lands in LOOKUP.
                rd_idx = bus.cbus_addr_i[SET_WIDTH+OFF_WIDTH-1:OFF_WIDTH];
                if (cmd_valid) begin
                    cmd_d   = cmd_in;
                    line_d  = bus.cbus_addr_i[ADDR_WIDTH-1:OFF_WIDTH];
                    state_d = FSM_LOOKUP;
                end else begin
                    bus.upd_ready_o = 1'b1;
                    if (bus.upd_valid_i) begin
                        we      = 1'b1;
                        wr_idx  = bus.upd_addr_i[SET_WIDTH+OFF_WIDTH-1:OFF_WIDTH];
                        wr_data = {bus.upd_addr_i[ADDR_WIDTH-1:SET_WIDTH+OFF_WIDTH],
                                   bus.upd_state_i};
                    end
                end
            end
            FSM_LOOKUP: begin
                state_d = FSM_ACK;
                case (cmd_q)
                    CMD_WR_SNOOP: begin
                        if (hit && ent_state == MESI_M) begin
                            pend_d  = MESI_I;
                            state_d = FSM_WB;
                        end else if (hit) begin
                            we      = 1'b1;
                            wr_data = {line_tag, MESI_I};
                        end
                    end
                    CMD_RD_SNOOP: begin
                        if (hit && ent_state == MESI_M) begin
                            pend_d  = MESI_S;
                            state_d = FSM_WB;
                        end else if (hit && ent_state == MESI_E) begin
                            we      = 1'b1;
                            wr_data = {line_tag, MESI_S};
                        end
                    end
                    default: state_d = FSM_EN_WAIT;
                endcase
            end
            FSM_WB: begin
                bus.wb_req_o  = 1'b1;
                bus.wb_addr_o = {line_q, {OFF_WIDTH{1'b0}}};
                if (bus.wb_done_i) begin
                    we      = 1'b1;
                    state_d = FSM_ACK;
                end
            end
            FSM_EN_WAIT: begin
                bus.en_o    = 1'b1;
                bus.en_wr_o = (cmd_q == CMD_EN_WR);
                if (bus.local_done_i) begin
                    we      = 1'b1;
                    wr_data = {line_tag, (cmd_q == CMD_EN_WR) ? MESI_M : MESI_S};
                    state_d = FSM_ACK;
                end
            end
            FSM_ACK: begin
                bus.cbus_ack_o = 1'b1;
                state_d        = FSM_WAIT_NOP;
            end
            FSM_WAIT_NOP: begin
                if (bus.cbus_cmd_i == '0) begin
                    state_d = FSM_IDLE;
                end
            end
            default: state_d = FSM_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mesi_isc_cbus_resp.sv
// Scoreboard bench for mesi_isc_cbus_resp: stimulus pushes expected acks from
// an array-of-lines reference model, a negedge monitor pops and compares.
module tb_mesi_isc_cbus_resp;

    logic clk;
    logic rst;
    int unsigned cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int unsigned cmd;
        int unsigned ack_cyc;
        bit          wb;
        logic [31:0] wb_addr;
        bit          en;
        bit          en_wr;
    } exp_t;

    exp_t sb[$];

    // Reference model: 16 lines, tag = addr/64, index = (addr/4)%16, state I=0 S=1 E=2 M=3
    int unsigned mtag[16];
    int unsigned mst[16];

    bit          saw_wb, saw_en, got_en_wr;
    logic [31:0] got_wb_addr;

    mesi_isc_cbus_resp_if #(.CBUS_CMD_WIDTH(3), .ADDR_WIDTH(32)) bus ();

    mesi_isc_cbus_resp #(
        .CBUS_CMD_WIDTH (3),
        .ADDR_WIDTH     (32),
        .SET_WIDTH      (4),
        .OFF_WIDTH      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mtag[i] = 0;
            mst[i]  = 0;
        end
    endtask

    // Monitor: accumulate what the DUT showed since the last ack, compare on ack.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            saw_wb = 0;
            saw_en = 0;
        end else begin
            if (bus.wb_req_o) begin
                saw_wb      = 1;
                got_wb_addr = bus.wb_addr_o;
            end
            if (bus.en_o) begin
                saw_en    = 1;
                got_en_wr = bus.en_wr_o;
            end
            if (bus.cbus_ack_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("ack_cycle_cmd%0d", e.cmd), cyc, e.ack_cyc);
                    chk($sformatf("wb_req_cmd%0d", e.cmd), saw_wb, e.wb);
                    if (e.wb) chk("wb_addr", got_wb_addr, e.wb_addr);
                    chk($sformatf("en_cmd%0d", e.cmd), saw_en, e.en);
                    if (e.en) chk("en_wr", got_en_wr, e.en_wr);
                end
                saw_wb = 0;
                saw_en = 0;
            end
        end
    end

    // Issue one command at a negedge; expectation comes from the model.
    task automatic do_cmd(input int unsigned c, input logic [31:0] a, input int unsigned hold,
                          input int unsigned d, input bit spur, input bit chk_blk);
        exp_t        e;
        int unsigned idx, tag, st;
        bit          hit, waitp;
        idx   = (a / 4) % 16;
        tag   = a / 64;
        st    = mst[idx];
        hit   = (mtag[idx] == tag) && (st != 0);
        e.cmd = c;
        e.wb  = 0;
        e.en  = 0;
        e.en_wr   = 0;
        e.wb_addr = a - (a % 4);
        waitp = 0;
        case (c)
            1: if (hit && st == 3) begin e.wb = 1; waitp = 1; mst[idx] = 0; end
               else if (hit) mst[idx] = 0;
            2: if (hit && st == 3) begin e.wb = 1; waitp = 1; mst[idx] = 1; end
               else if (hit && st == 2) mst[idx] = 1;
            default: begin
                e.en = 1;
                e.en_wr = (c == 3);
                waitp = 1;
                mtag[idx] = tag;
                mst[idx]  = (c == 3) ? 3 : 1;
            end
        endcase
        e.ack_cyc = waitp ? cyc + 3 + d : cyc + 2;
        bus.cbus_cmd_i  = 3'(c);
        bus.cbus_addr_i = a;
        if (spur) begin
            bus.wb_done_i    = 1;
            bus.local_done_i = 1;
        end
        sb.push_back(e);
        if (chk_blk) begin
            #1 chk("upd_ready_blocked_by_cmd", bus.upd_ready_o, 0);
        end
        @(negedge clk);
        bus.wb_done_i    = 0;
        bus.local_done_i = 0;
        if (waitp) begin
            repeat (1 + d) @(negedge clk);
            if (e.wb) bus.wb_done_i = 1;
            else      bus.local_done_i = 1;
            @(negedge clk);
            bus.wb_done_i    = 0;
            bus.local_done_i = 0;
        end else begin
            @(negedge clk);
        end
        repeat (hold) @(negedge clk);
        bus.cbus_cmd_i = 3'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_upd(input logic [31:0] a, input int unsigned s);
        bus.upd_valid_i = 1;
        bus.upd_addr_i  = a;
        bus.upd_state_i = 2'(s);
        #1 chk("upd_ready_idle", bus.upd_ready_o, 1);
        @(negedge clk);
        bus.upd_valid_i = 0;
        mtag[(a / 4) % 16] = a / 64;
        mst[(a / 4) % 16]  = s;
    endtask

    initial begin
        int unsigned c0;
        rst              = 1;
        bus.cbus_cmd_i   = 0;
        bus.cbus_addr_i  = 0;
        bus.wb_done_i    = 0;
        bus.local_done_i = 0;
        bus.upd_valid_i  = 0;
        bus.upd_addr_i   = 0;
        bus.upd_state_i  = 0;
        model_clear();
        saw_wb = 0;
        saw_en = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_ack", bus.cbus_ack_o, 0);
        chk("rst_wb_req", bus.wb_req_o, 0);
        chk("rst_wb_addr", bus.wb_addr_o, 0);
        chk("rst_en", bus.en_o, 0);
        chk("rst_en_wr", bus.en_wr_o, 0);
        chk("rst_upd_ready", bus.upd_ready_o, 1);
        @(negedge clk);

        // Miss snoop, then again to show the array was left alone
        do_cmd(2, 32'h40, 0, 0, 0, 0);
        do_cmd(2, 32'h40, 0, 0, 0, 0);

        // Modified line snooped through an unaligned address
        do_upd(32'h100, 3);
        do_cmd(1, 32'h103, 0, 3, 0, 0);
        do_cmd(2, 32'h100, 0, 0, 0, 0);

        // Exclusive line downgraded, then invalidated
        do_upd(32'h200, 2);
        do_cmd(2, 32'h200, 0, 0, 0, 0);
        do_cmd(2, 32'h200, 0, 0, 0, 0);
        do_cmd(1, 32'h200, 0, 0, 0, 0);

        // Write grant with the command held past the ack
        do_cmd(3, 32'h300, 1, 2, 0, 0);
        do_cmd(1, 32'h300, 0, 1, 0, 0);

        // Update arriving together with a command waits for IDLE
        bus.upd_valid_i = 1;
        bus.upd_addr_i  = 32'h200;
        bus.upd_state_i = 2'd3;
        do_cmd(1, 32'h500, 0, 0, 1, 1);
        #1 chk("upd_ready_after_cmd", bus.upd_ready_o, 1);
        @(negedge clk);
        bus.upd_valid_i = 0;
        mtag[0] = 32'h200 / 64;
        mst[0]  = 3;
        do_cmd(2, 32'h200, 0, 0, 0, 0);
        do_cmd(4, 32'h7c, 0, 0, 0, 0);

        // Reserved codes behave as NOP
        bus.cbus_cmd_i = 3'(5 + $urandom_range(0, 2));
        #1 chk("upd_ready_reserved_cmd", bus.upd_ready_o, 1);
        repeat (3) @(negedge clk);
        bus.cbus_cmd_i = 0;
        @(negedge clk);

        // Reset in the middle of a write-back
        do_upd(32'h100, 3);
        c0 = cyc;
        bus.cbus_cmd_i  = 3'd1;
        bus.cbus_addr_i = 32'h100;
        repeat (2) @(negedge clk);
        chk("wb_req_before_rst", bus.wb_req_o, 1);
        chk("wb_cycle_before_rst", cyc, c0 + 2);
        #2 rst = 1;
        #1;
        chk("wb_req_on_rst", bus.wb_req_o, 0);
        chk("ack_on_rst", bus.cbus_ack_o, 0);
        chk("wb_addr_on_rst", bus.wb_addr_o, 0);
        bus.cbus_cmd_i = 0;
        model_clear();
        @(negedge clk);
        #1 rst = 0;
        @(negedge clk);
        do_cmd(2, 32'h100, 0, 0, 0, 0);

        // Randomized mix over a small address pool so hits are common
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) < 3)
                do_upd(a, $urandom_range(0, 3));
            else
                do_cmd($urandom_range(1, 4), a, $urandom_range(0, 2), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), 0);
        end

        repeat (4) @(negedge clk);
        chk("pending_acks", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
